// File: rtl/cceip_apb2rbus_pkg.sv
// Shared types and constants for the CCEIP APB3 to rbus bridge.
// Holds the FSM state enum, rbus word shift and timeout counter sizing.
package cceip_apb2rbus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STRB,
    S_WAIT,
    S_RESP
  } apb2rbus_state_e;

  // Byte address to rbus word address shift.
  localparam int unsigned RBUS_WORD_SHIFT = 2;

  // Counter width able to hold the value TIMEOUT.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cceip_apb2rbus_bridge.sv
// APB3 slave turning each APB transfer into one rbus strobe/ack access.
// Ports: ap_clk/areset, s_apb_* slave side, rbus_* master side, timeout_evt.
module cceip_apb2rbus_bridge
  import cceip_apb2rbus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_LIMIT = 32'h40000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          s_apb_paddr,
  input  logic                       s_apb_psel,
  input  logic                       s_apb_penable,
  input  logic                       s_apb_pwrite,
  input  logic [DATA_W-1:0]          s_apb_pwdata,
  output logic                       s_apb_pready,
  output logic [DATA_W-1:0]          s_apb_prdata,
  output logic                       s_apb_pslverr,
  output logic [ADDR_W-RBUS_WORD_SHIFT-1:0] rbus_addr,
  output logic [DATA_W-1:0]          rbus_wdata,
  output logic                       rbus_wr_strb,
  output logic                       rbus_rd_strb,
  input  logic                       rbus_ack,
  input  logic [DATA_W-1:0]          rbus_rdata,
  input  logic                       rbus_err,
  output logic                       timeout_evt
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(ADDR_LIMIT);
  // Counter value in the last WAIT cycle before timing out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb2rbus_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_q;
  logic             pready_q;
  logic [DATA_W-1:0] prdata_q;
  logic             pslverr_q;
  logic [ADDR_W-RBUS_WORD_SHIFT-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic             wr_strb_q;
  logic             rd_strb_q;
  logic             to_evt_q;

  logic setup;
  logic bad;

  assign setup = s_apb_psel & ~s_apb_penable;
  assign bad   = (s_apb_paddr[RBUS_WORD_SHIFT-1:0] != '0)
               | ({1'b0, s_apb_paddr} >= LIMIT);

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_strb_q <= 1'b0;
      rd_strb_q <= 1'b0;
      to_evt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (setup) begin
            wr_q    <= s_apb_pwrite;
            addr_q  <= s_apb_paddr[ADDR_W-1:RBUS_WORD_SHIFT];
            wdata_q <= s_apb_pwdata;
            if (bad) begin
              state_q   <= S_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= '0;
            end else begin
              state_q   <= S_STRB;
              wr_strb_q <= s_apb_pwrite;
              rd_strb_q <= ~s_apb_pwrite;
            end
          end
        end
        S_STRB: begin
          wr_strb_q <= 1'b0;
          rd_strb_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Ack has priority over a timeout landing in the same cycle.
          if (rbus_ack) begin
            prdata_q  <= wr_q ? '0 : rbus_rdata;
            pslverr_q <= rbus_err;
            pready_q  <= 1'b1;
            state_q   <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b1;
            to_evt_q  <= 1'b1;
            pready_q  <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          to_evt_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_apb_pready  = pready_q;
  assign s_apb_prdata  = prdata_q;
  assign s_apb_pslverr = pslverr_q;
  assign rbus_addr     = addr_q;
  assign rbus_wdata    = wdata_q;
  assign rbus_wr_strb  = wr_strb_q;
  assign rbus_rd_strb  = rd_strb_q;
  assign timeout_evt   = to_evt_q;

endmodule

// File: tb/tb_cceip_apb2rbus_bridge.sv
// Directed scoreboard bench for cceip_apb2rbus_bridge.
// Models an rbus target with programmable ack delay.
module tb_cceip_apb2rbus_bridge;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic [19:0] s_apb_paddr;
  logic        s_apb_psel;
  logic        s_apb_penable;
  logic        s_apb_pwrite;
  logic [31:0] s_apb_pwdata;
  logic        s_apb_pready;
  logic [31:0] s_apb_prdata;
  logic        s_apb_pslverr;
  logic [17:0] rbus_addr;
  logic [31:0] rbus_wdata;
  logic        rbus_wr_strb;
  logic        rbus_rd_strb;
  logic        rbus_ack;
  logic [31:0] rbus_rdata;
  logic        rbus_err;
  logic        timeout_evt;

  cceip_apb2rbus_bridge dut (
    .ap_clk        (ap_clk),
    .areset        (areset),
    .s_apb_paddr   (s_apb_paddr),
    .s_apb_psel    (s_apb_psel),
    .s_apb_penable (s_apb_penable),
    .s_apb_pwrite  (s_apb_pwrite),
    .s_apb_pwdata  (s_apb_pwdata),
    .s_apb_pready  (s_apb_pready),
    .s_apb_prdata  (s_apb_prdata),
    .s_apb_pslverr (s_apb_pslverr),
    .rbus_addr     (rbus_addr),
    .rbus_wdata    (rbus_wdata),
    .rbus_wr_strb  (rbus_wr_strb),
    .rbus_rd_strb  (rbus_rd_strb),
    .rbus_ack      (rbus_ack),
    .rbus_rdata    (rbus_rdata),
    .rbus_err      (rbus_err),
    .timeout_evt   (timeout_evt)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        to;
    int          nstrb;
    logic        wr;
    logic [17:0] addr;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // rbus target model controls (written only by the initial block)
  int          ack_delay = 0;
  logic [31:0] ack_rdata = '0;
  logic        ack_err   = 1'b0;
  int          force_req = 0;

  // rbus target model state (written only by the responder)
  int          ack_cnt   = 0;
  int          force_done = 0;
  int          strb_cyc  = 0;
  logic        last_wr   = 1'b0;
  logic [17:0] last_addr = '0;
  logic [31:0] last_wd   = '0;

  initial begin
    rbus_ack   = 1'b0;
    rbus_rdata = '0;
    rbus_err   = 1'b0;
  end

  always @(posedge ap_clk) begin
    #1;
    rbus_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt = ack_cnt - 1;
      if (ack_cnt == 0) begin
        rbus_ack   = 1'b1;
        rbus_rdata = ack_rdata;
        rbus_err   = ack_err;
      end
    end
    if (force_req != force_done) begin
      force_done = force_req;
      rbus_ack   = 1'b1;
      rbus_rdata = 32'hFFFF_0000;
      rbus_err   = 1'b1;
    end
    if (rbus_wr_strb || rbus_rd_strb) begin
      strb_cyc  = strb_cyc + 1;
      last_wr   = rbus_wr_strb;
      last_addr = rbus_addr;
      last_wd   = rbus_wdata;
      if (ack_delay > 0) ack_cnt = ack_delay;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [19:0] a, input logic w,
                      input logic [31:0] wd, input int ad,
                      input logic [31:0] ard, input logic ae,
                      input int elat, input logic [31:0] erd,
                      input logic eerr, input logic eto,
                      input string tag);
    exp_t e;
    int s0;
    int lat;
    bit got;
    logic [31:0] o_rd;
    logic o_err;
    logic o_to;
    e.rd = erd; e.err = eerr; e.lat = elat; e.to = eto;
    e.nstrb = (elat == 1) ? 0 : 1;
    e.wr = w; e.addr = a[19:2]; e.wd = wd;
    sb.push_back(e);
    ack_delay = ad;
    ack_rdata = ard;
    ack_err   = ae;
    @(posedge ap_clk); #1;
    s_apb_psel    = 1'b1;
    s_apb_penable = 1'b0;
    s_apb_paddr   = a;
    s_apb_pwrite  = w;
    s_apb_pwdata  = wd;
    s0  = strb_cyc;
    got = 1'b0;
    lat = -1;
    o_rd = 'x; o_err = 1'bx; o_to = 1'bx;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(posedge ap_clk); #1;
      s_apb_penable = 1'b1;
      @(negedge ap_clk);
      if (s_apb_pready) begin
        got   = 1'b1;
        lat   = k;
        o_rd  = s_apb_prdata;
        o_err = s_apb_pslverr;
        o_to  = timeout_evt;
      end
    end
    e = sb.pop_front();
    chk({tag, "/latency"}, lat, e.lat);
    chk({tag, "/prdata"}, o_rd, e.rd);
    chk({tag, "/pslverr"}, {31'b0, o_err}, {31'b0, e.err});
    chk({tag, "/timeout_evt"}, {31'b0, o_to}, {31'b0, e.to});
    chk({tag, "/strobe_cycles"}, strb_cyc - s0, e.nstrb);
    if (e.nstrb == 1) begin
      chk({tag, "/strb_kind"}, {31'b0, last_wr}, {31'b0, e.wr});
      chk({tag, "/rbus_addr"}, {14'b0, last_addr}, {14'b0, e.addr});
      if (e.wr) chk({tag, "/rbus_wdata"}, last_wd, e.wd);
    end
  endtask

  task automatic idle_cycles(input int n, output int pr_seen);
    pr_seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge ap_clk); #1;
      s_apb_psel    = 1'b0;
      s_apb_penable = 1'b0;
      @(negedge ap_clk);
      if (s_apb_pready) pr_seen++;
    end
  endtask

  int seen;

  initial begin
    areset        = 1'b1;
    s_apb_paddr   = '0;
    s_apb_psel    = 1'b0;
    s_apb_penable = 1'b0;
    s_apb_pwrite  = 1'b0;
    s_apb_pwdata  = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst/pready", {31'b0, s_apb_pready}, 32'd0);
    chk("rst/pslverr", {31'b0, s_apb_pslverr}, 32'd0);
    chk("rst/prdata", s_apb_prdata, 32'd0);
    chk("rst/rbus_addr", {14'b0, rbus_addr}, 32'd0);
    chk("rst/rbus_wdata", rbus_wdata, 32'd0);
    chk("rst/strobes", {30'b0, rbus_wr_strb, rbus_rd_strb}, 32'd0);
    chk("rst/timeout_evt", {31'b0, timeout_evt}, 32'd0);
    @(posedge ap_clk); #1;
    areset = 1'b0;

    xfer(20'h00104, 1'b1, 32'hDEADBEEF, 3, 32'h5555_5555, 1'b0,
         5, 32'h0, 1'b0, 1'b0, "wr104");
    xfer(20'h00200, 1'b0, 32'h0, 1, 32'h12345678, 1'b0,
         3, 32'h12345678, 1'b0, 1'b0, "rd200");
    xfer(20'h00202, 1'b0, 32'h0, 1, 32'h11111111, 1'b0,
         1, 32'h0, 1'b1, 1'b0, "rd202_misalign");
    xfer(20'h40000, 1'b1, 32'hAAAA5555, 1, 32'h0, 1'b0,
         1, 32'h0, 1'b1, 1'b0, "wr40000_range");
    xfer(20'h3FFFC, 1'b0, 32'h0, 2, 32'hA5A5_0F0F, 1'b0,
         4, 32'hA5A5_0F0F, 1'b0, 1'b0, "rd3fffc_last");
    xfer(20'h00300, 1'b0, 32'h0, 2, 32'hCAFEF00D, 1'b1,
         4, 32'hCAFEF00D, 1'b1, 1'b0, "rd300_rbus_err");

    // No ack at all: timeout, then a late ack must be ignored.
    xfer(20'h00400, 1'b0, 32'h0, 0, 32'h0, 1'b0,
         257, 32'h0, 1'b1, 1'b1, "rd400_timeout");
    idle_cycles(4, seen);
    force_req++;
    idle_cycles(4, seen);
    chk("late_ack/no_pready", seen, 0);
    xfer(20'h00408, 1'b1, 32'h0BAD_F00D, 2, 32'h0, 1'b0,
         4, 32'h0, 1'b0, 1'b0, "wr408_after_to");

    // Reset while waiting for ack.
    ack_delay = 0;
    @(posedge ap_clk); #1;
    s_apb_psel    = 1'b1;
    s_apb_penable = 1'b0;
    s_apb_paddr   = 20'h00010;
    s_apb_pwrite  = 1'b1;
    s_apb_pwdata  = 32'h7777_7777;
    @(posedge ap_clk); #1;
    s_apb_penable = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    areset = 1'b1;
    #1;
    chk("midrst/pready", {31'b0, s_apb_pready}, 32'd0);
    chk("midrst/rbus_addr", {14'b0, rbus_addr}, 32'd0);
    chk("midrst/rbus_wdata", rbus_wdata, 32'd0);
    chk("midrst/strobes", {30'b0, rbus_wr_strb, rbus_rd_strb}, 32'd0);
    s_apb_psel    = 1'b0;
    s_apb_penable = 1'b0;
    @(posedge ap_clk); #1;
    areset = 1'b0;
    @(negedge ap_clk);
    force_req++;
    idle_cycles(4, seen);
    chk("post_rst_ack/no_pready", seen, 0);
    xfer(20'h00020, 1'b0, 32'h0, 1, 32'h0BADCAFE, 1'b0,
         3, 32'h0BADCAFE, 1'b0, 1'b0, "rd020_after_rst");

    chk("scoreboard/empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
